// File: rtl/fight_pkg.sv
// Shared state codes and attacker FSM type for the fight hit-resolution logic.
package fight_pkg;

  localparam logic [3:0] StBasicStart  = 4'd3;
  localparam logic [3:0] StBasicActive = 4'd4;
  localparam logic [3:0] StBasicRecov  = 4'd5;
  localparam logic [3:0] StDirStart    = 4'd6;
  localparam logic [3:0] StDirActive   = 4'd7;
  localparam logic [3:0] StDirRecov    = 4'd8;
  localparam logic [3:0] StBlock       = 4'd9;

  typedef enum logic [1:0] {
    AtkIdle,
    AtkArmed,
    AtkSpent
  } atk_state_e;

  function automatic logic is_active(logic [3:0] s);
    return (s == StBasicActive) || (s == StDirActive);
  endfunction

endpackage

// File: rtl/hit_resolver_if.sv
// Player-state inputs and hit-result outputs of the hit resolver, bundled as one interface.
interface hit_resolver_if #(
  parameter int unsigned X_W = 10
);
  logic [3:0]     p1_state;
  logic [3:0]     p2_state;
  logic [X_W-1:0] p1_x;
  logic [X_W-1:0] p2_x;
  logic           hit_p1;
  logic           hit_p2;
  logic [1:0]     hit_dir;
  logic           trade;
  logic           p1_invuln;
  logic           p2_invuln;
  logic           blk_p1;
  logic           blk_p2;

  modport master (
    output p1_state, p2_state, p1_x, p2_x,
    input  hit_p1, hit_p2, hit_dir, trade, p1_invuln, p2_invuln, blk_p1, blk_p2
  );

  modport slave (
    input  p1_state, p2_state, p1_x, p2_x,
    output hit_p1, hit_p2, hit_dir, trade, p1_invuln, p2_invuln, blk_p1, blk_p2
  );
endinterface

// File: rtl/hit_channel.sv
// One attack direction: attacker IDLE/ARMED/SPENT FSM, victim invulnerability counter and
// registered hit/block/direction pulses.
module hit_channel
  import fight_pkg::*;
#(
  parameter int unsigned INVULN_CYCLES = 8,
  parameter int unsigned CNT_W         = 8,
  parameter bit          BlockEn       = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] atk_state_i,
  input  logic       overlap_i,
  input  logic       victim_block_i,
  output logic       hit_o,
  output logic       blk_o,
  output logic       dir_o,
  output logic       invuln_o
);

  localparam logic [CNT_W-1:0] LoadHit = CNT_W'(INVULN_CYCLES);
  localparam logic [CNT_W-1:0] LoadBlk = CNT_W'(INVULN_CYCLES / 2);

  atk_state_e       st_q, st_d, st_eff;
  logic [3:0]       prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d, blk_q, blk_d, dir_q, dir_d;
  logic             connect, blocked;

  always_comb begin
    st_eff  = st_q;
    st_d    = st_q;
    connect = 1'b0;
    blocked = BlockEn && victim_block_i;
    cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
    hit_d   = 1'b0;
    blk_d   = 1'b0;
    dir_d   = 1'b0;

    // Arming takes effect in the same cycle, so the first active cycle can already connect.
    // A direct 4 <-> 7 change is a fresh attack and re-arms a spent attacker.
    if (!is_active(atk_state_i)) begin
      st_eff = AtkIdle;
    end else if (st_q == AtkIdle || atk_state_i != prev_q) begin
      st_eff = AtkArmed;
    end

    connect = (st_eff == AtkArmed) && overlap_i && (cnt_q == '0);
    st_d    = connect ? AtkSpent : st_eff;

    if (connect) begin
      cnt_d = blocked ? LoadBlk : LoadHit;
      hit_d = !blocked;
      blk_d = blocked;
      dir_d = (atk_state_i == StDirActive);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= AtkIdle;
      prev_q <= '0;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      blk_q  <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      prev_q <= atk_state_i;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
      blk_q  <= blk_d;
      dir_q  <= dir_d;
    end
  end

  assign hit_o    = hit_q;
  assign blk_o    = BlockEn ? blk_q : 1'b0;
  assign dir_o    = dir_q;
  assign invuln_o = (cnt_q != '0);

endmodule

// File: rtl/hit_resolver.sv
// Registered hit resolver: facing, hit/hurt geometry and two per-direction hit channels.
// Optional blocking (state code 9) is enabled by defining HIT_BLOCK_EN.
module hit_resolver
  import fight_pkg::*;
#(
  parameter int unsigned X_W           = 10,
  parameter int unsigned PLAYER_W      = 64,
  parameter int unsigned BASIC_REACH   = 70,
  parameter int unsigned BASIC_HURT    = 60,
  parameter int unsigned DIR_REACH     = 40,
  parameter int unsigned DIR_HURT      = 30,
  parameter int unsigned INVULN_CYCLES = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic           clk,
  input  logic           reset,
  hit_resolver_if.slave  bus
);

`ifdef HIT_BLOCK_EN
  localparam bit BlockEn = 1'b1;
`else
  localparam bit BlockEn = 1'b0;
`endif

  localparam int unsigned SW = X_W + 2;
  typedef logic signed [SW-1:0] sx_t;

  sx_t  x1, x2;
  logic p1_right;
  logic p1_strikes, p2_strikes;
  logic p1_blocking, p2_blocking;

  // Two extra bits keep x+body+reach positive and x-reach representable without wrap.
  function automatic logic strikes(sx_t ax, logic [3:0] ast, logic ar,
                                   sx_t vx, logic [3:0] vst, logic vr);
    sx_t reach, ext, a_lo, a_hi, v_lo, v_hi;
    reach = (ast == StDirActive) ? sx_t'(DIR_REACH) : sx_t'(BASIC_REACH);
    ext   = '0;
    if (vst == StBasicActive || vst == StBasicRecov) begin
      ext = sx_t'(BASIC_HURT);
    end else if (vst == StDirActive || vst == StDirRecov) begin
      ext = sx_t'(DIR_HURT);
    end
    if (ar) begin
      a_lo = ax + sx_t'(PLAYER_W);
      a_hi = a_lo + reach - sx_t'(1);
    end else begin
      a_lo = ax - reach;
      a_hi = ax - sx_t'(1);
    end
    v_lo = vx;
    v_hi = vx + sx_t'(PLAYER_W) - sx_t'(1);
    if (vr) begin
      v_hi = v_hi + ext;
    end else begin
      v_lo = v_lo - ext;
    end
    return (a_lo <= v_hi) && (v_lo <= a_hi);
  endfunction

  assign x1       = sx_t'({2'b00, bus.p1_x});
  assign x2       = sx_t'({2'b00, bus.p2_x});
  assign p1_right = (bus.p1_x <= bus.p2_x);

  assign p1_strikes = strikes(x1, bus.p1_state, p1_right, x2, bus.p2_state, !p1_right);
  assign p2_strikes = strikes(x2, bus.p2_state, !p1_right, x1, bus.p1_state, p1_right);

  assign p1_blocking = BlockEn && (bus.p1_state == StBlock);
  assign p2_blocking = BlockEn && (bus.p2_state == StBlock);

  hit_channel #(
    .INVULN_CYCLES (INVULN_CYCLES),
    .CNT_W         (CNT_W),
    .BlockEn       (BlockEn)
  ) u_p1_on_p2 (
    .clk            (clk),
    .reset          (reset),
    .atk_state_i    (bus.p1_state),
    .overlap_i      (p1_strikes),
    .victim_block_i (p2_blocking),
    .hit_o          (bus.hit_p2),
    .blk_o          (bus.blk_p2),
    .dir_o          (bus.hit_dir[1]),
    .invuln_o       (bus.p2_invuln)
  );

  hit_channel #(
    .INVULN_CYCLES (INVULN_CYCLES),
    .CNT_W         (CNT_W),
    .BlockEn       (BlockEn)
  ) u_p2_on_p1 (
    .clk            (clk),
    .reset          (reset),
    .atk_state_i    (bus.p2_state),
    .overlap_i      (p2_strikes),
    .victim_block_i (p1_blocking),
    .hit_o          (bus.hit_p1),
    .blk_o          (bus.blk_p1),
    .dir_o          (bus.hit_dir[0]),
    .invuln_o       (bus.p1_invuln)
  );

  assign bus.trade = bus.hit_p1 & bus.hit_p2;

endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: single-shot vector table plus multi-cycle sequences.
module tb_hit_resolver;

  localparam logic [8:0] H1 = 9'h100;
  localparam logic [8:0] H2 = 9'h080;
  localparam logic [8:0] D1 = 9'h040;
  localparam logic [8:0] D0 = 9'h020;
  localparam logic [8:0] TR = 9'h010;
  localparam logic [8:0] I1 = 9'h008;
  localparam logic [8:0] I2 = 9'h004;
  localparam int NumVec = 20;

  typedef struct {
    logic [3:0] s1;
    logic [3:0] s2;
    logic [9:0] x1;
    logic [9:0] x2;
    logic [8:0] exp;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  vec_t       vecs[NumVec];

  always #5 clk = ~clk;

  hit_resolver_if #(.X_W(10)) bus ();

  hit_resolver #(
    .X_W           (10),
    .PLAYER_W      (64),
    .BASIC_REACH   (70),
    .BASIC_HURT    (60),
    .DIR_REACH     (40),
    .DIR_HURT      (30),
    .INVULN_CYCLES (8),
    .CNT_W         (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [8:0] observed();
    return {bus.hit_p1, bus.hit_p2, bus.hit_dir[1], bus.hit_dir[0], bus.trade,
            bus.p1_invuln, bus.p2_invuln, bus.blk_p1, bus.blk_p2};
  endfunction

  task automatic check_out();
    logic [8:0] e;
    logic [8:0] o;
    string      nm;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got output with no expectation queued");
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      o  = observed();
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: got %b want %b (h1 h2 d1 d0 tr i1 i2 b1 b2)", nm, o, e);
      end
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic r, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [9:0] x1, input logic [9:0] x2,
                      input logic [8:0] e, input string nm);
    reset        = r;
    bus.p1_state = s1;
    bus.p2_state = s2;
    bus.p1_x     = x1;
    bus.p2_x     = x2;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'd4, 4'd0, 10'd100, 10'd220, H2 | I2, "basic_hit"};
    vecs[1]  = '{4'd7, 4'd0, 10'd100, 10'd220, 9'h000, "dir_miss"};
    vecs[2]  = '{4'd7, 4'd0, 10'd100, 10'd200, H2 | D1 | I2, "dir_hit"};
    vecs[3]  = '{4'd4, 4'd4, 10'd100, 10'd200, H1 | H2 | TR | I1 | I2, "basic_trade"};
    vecs[4]  = '{4'd4, 4'd0, 10'd300, 10'd150, 9'h000, "crossed_miss"};
    vecs[5]  = '{4'd4, 4'd0, 10'd300, 10'd200, H2 | I2, "crossed_hit"};
    vecs[6]  = '{4'd4, 4'd0, 10'd10,  10'd0,   H2 | I2, "neg_low_edge"};
    vecs[7]  = '{4'd0, 4'd4, 10'd100, 10'd200, H1 | I1, "p2_basic_left"};
    vecs[8]  = '{4'd0, 4'd7, 10'd100, 10'd200, H1 | D0 | I1, "p2_dir_left"};
    vecs[9]  = '{4'd3, 4'd0, 10'd100, 10'd200, 9'h000, "startup_no_hit"};
    vecs[10] = '{4'd5, 4'd0, 10'd100, 10'd164, 9'h000, "recovery_no_hit"};
    vecs[11] = '{4'd4, 4'd0, 10'd100, 10'd233, H2 | I2, "reach_edge_in"};
    vecs[12] = '{4'd4, 4'd0, 10'd100, 10'd234, 9'h000, "reach_edge_out"};
    vecs[13] = '{4'd4, 4'd0, 10'd100, 10'd100, 9'h000, "equal_x"};
    vecs[14] = '{4'd9, 4'd4, 10'd100, 10'd200, H1 | I1, "code9_neutral"};
    vecs[15] = '{4'd7, 4'd5, 10'd100, 10'd250, H2 | D1 | I2, "basic_hurt_ext_left"};
    vecs[16] = '{4'd7, 4'd8, 10'd100, 10'd233, H2 | D1 | I2, "dir_hurt_ext_in"};
    vecs[17] = '{4'd7, 4'd8, 10'd100, 10'd234, 9'h000, "dir_hurt_ext_out"};
    vecs[18] = '{4'd7, 4'd7, 10'd100, 10'd200, H1 | H2 | D1 | D0 | TR | I1 | I2, "dir_trade"};
    vecs[19] = '{4'd5, 4'd7, 10'd100, 10'd260, H1 | D0 | I1, "basic_hurt_ext_right"};

    step(1'b1, 4'd4, 4'd0, 10'd100, 10'd200, 9'h000, "reset_0");
    step(1'b1, 4'd4, 4'd0, 10'd100, 10'd200, 9'h000, "reset_1");

    for (int i = 0; i < NumVec; i++) begin
      step(1'b1, 4'd0, 4'd0, vecs[i].x1, vecs[i].x2, 9'h000, "vec_reset");
      step(1'b0, vecs[i].s1, vecs[i].s2, vecs[i].x1, vecs[i].x2, vecs[i].exp, vecs[i].name);
    end

    // Single hit per activation and an 8-cycle invulnerability window.
    step(1'b1, 4'd0, 4'd0, 10'd100, 10'd220, 9'h000, "seqA_reset");
    step(1'b0, 4'd3, 4'd0, 10'd100, 10'd220, 9'h000, "seqA_start");
    step(1'b0, 4'd4, 4'd0, 10'd100, 10'd220, H2 | I2, "seqA_hit");
    for (int i = 0; i < 4; i++) step(1'b0, 4'd4, 4'd0, 10'd100, 10'd220, I2, "seqA_held");
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 4'd0, 10'd100, 10'd220, I2, "seqA_tail");
    step(1'b0, 4'd0, 4'd0, 10'd100, 10'd220, 9'h000, "seqA_invuln_end");

    // Crossed sides, then 4 -> 7 re-arms but waits out the invulnerability window.
    step(1'b1, 4'd0, 4'd0, 10'd300, 10'd200, 9'h000, "seqB_reset");
    step(1'b0, 4'd4, 4'd0, 10'd300, 10'd200, H2 | I2, "seqB_hit");
    for (int i = 0; i < 7; i++) step(1'b0, 4'd7, 4'd0, 10'd300, 10'd200, I2, "seqB_gated");
    step(1'b0, 4'd7, 4'd0, 10'd300, 10'd200, 9'h000, "seqB_clear");
    step(1'b0, 4'd7, 4'd0, 10'd300, 10'd200, H2 | D1 | I2, "seqB_rearm_hit");
    step(1'b0, 4'd7, 4'd0, 10'd300, 10'd200, I2, "seqB_spent");

    // Negative low edge, then reset during invulnerability clears the counter.
    step(1'b1, 4'd0, 4'd0, 10'd10, 10'd0, 9'h000, "seqC_reset");
    step(1'b0, 4'd4, 4'd0, 10'd10, 10'd0, H2 | I2, "seqC_hit");
    step(1'b0, 4'd4, 4'd0, 10'd10, 10'd0, I2, "seqC_invuln");
    step(1'b1, 4'd4, 4'd0, 10'd10, 10'd0, 9'h000, "seqC_reset_clears");
    step(1'b0, 4'd4, 4'd0, 10'd10, 10'd0, H2 | I2, "seqC_after_reset");
    step(1'b0, 4'd0, 4'd0, 10'd10, 10'd0, I2, "seqC_idle");

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d pending want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
